// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell is time-multiplexed over WIDTH cycles with a registered borrow.
// Results are registered and held until the next operation completes.
module serial_subtractor #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bin_i,
   output logic [WIDTH-1:0] diff_o,
   output logic             bout_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] res_sh_q;
   logic             br_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
   logic             busy_q;
   logic             done_q;

   logic             x_bit;
   logic             y_bit;
   logic             d_bit;
   logic             br_d;
   logic [WIDTH-1:0] res_sh_d;

   // Full-subtractor cell operating on the current LSBs and the stored borrow.
   always_comb begin
      x_bit    = a_sh_q[0];
      y_bit    = b_sh_q[0];
      d_bit    = x_bit ^ y_bit ^ br_q;
      br_d     = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
      res_sh_d = {d_bit, res_sh_q[WIDTH-1:1]};
   end

   // Control FSM with datapath shift registers and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               done_q <= 1'b0;
               // DONE accepts a new start exactly like IDLE, enabling back-to-back ops.
               if (start_i) begin
                  a_sh_q  <= a_i;
                  b_sh_q  <= b_i;
                  br_q    <= bin_i;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            StRun: begin
               res_sh_q <= res_sh_d;
               a_sh_q   <= a_sh_q >> 1;
               b_sh_q   <= b_sh_q >> 1;
               br_q     <= br_d;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == CntLast) begin
                  // Last bit: publish the full result including this cycle's bit.
                  diff_q  <= res_sh_d;
                  bout_q  <= br_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StDone;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign diff_o = diff_q;
   assign bout_o = bout_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed handshake scenarios at WIDTH=4 and a
// randomized arithmetic comparison at WIDTH=8 against a plain-arithmetic model.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       bin4 = 1'b0;
   logic [3:0] diff4;
   logic       bout4, busy4, done4;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       bin8 = 1'b0;
   logic [7:0] diff8;
   logic       bout8, busy8, done8;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(4)) u_dut4 (
      .clk     (clk),
      .rst     (rst),
      .start_i (start4),
      .a_i     (a4),
      .b_i     (b4),
      .bin_i   (bin4),
      .diff_o  (diff4),
      .bout_o  (bout4),
      .busy_o  (busy4),
      .done_o  (done4)
   );

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk     (clk),
      .rst     (rst),
      .start_i (start8),
      .a_i     (a8),
      .b_i     (b8),
      .bin_i   (bin8),
      .diff_o  (diff8),
      .bout_o  (bout8),
      .busy_o  (busy8),
      .done_o  (done8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model: unsigned modulo arithmetic.
   function automatic int exp_diff(input int w, input int a, input int b, input int bin);
      return (a - b - bin) & ((1 << w) - 1);
   endfunction

   function automatic int exp_bout(input int a, input int b, input int bin);
      return (a < b + bin) ? 1 : 0;
   endfunction

   function automatic logic [31:0] rd_diff(input bit w8);
      return w8 ? {24'd0, diff8} : {28'd0, diff4};
   endfunction
   function automatic logic rd_bout(input bit w8);
      return w8 ? bout8 : bout4;
   endfunction
   function automatic logic rd_busy(input bit w8);
      return w8 ? busy8 : busy4;
   endfunction
   function automatic logic rd_done(input bit w8);
      return w8 ? done8 : done4;
   endfunction

   // One full operation from IDLE; checks latency, held result, final result and idle return.
   task automatic do_op(input bit w8, input int a, input int b, input int bin, input string tag);
      int          w;
      int          cyc;
      logic [31:0] prev_diff;
      logic        prev_bout;
      w         = w8 ? 8 : 4;
      prev_diff = rd_diff(w8);
      prev_bout = rd_bout(w8);
      if (w8) begin
         a8 = a[7:0]; b8 = b[7:0]; bin8 = bin[0]; start8 = 1'b1;
      end else begin
         a4 = a[3:0]; b4 = b[3:0]; bin4 = bin[0]; start4 = 1'b1;
      end
      @(posedge clk); #1;
      // Operands may change freely after acceptance.
      if (w8) begin
         start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      end else begin
         start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      end
      chk({tag, "_busy"}, 32'(rd_busy(w8)), 32'd1);
      chk({tag, "_held_diff"}, rd_diff(w8), prev_diff);
      chk({tag, "_held_bout"}, 32'(rd_bout(w8)), 32'(prev_bout));
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!rd_done(w8) && cyc < 40);
      chk({tag, "_latency"}, 32'(cyc), 32'(w));
      chk({tag, "_diff"}, rd_diff(w8), 32'(exp_diff(w, a, b, bin)));
      chk({tag, "_bout"}, 32'(rd_bout(w8)), 32'(exp_bout(a, b, bin)));
      chk({tag, "_busy_at_done"}, 32'(rd_busy(w8)), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 32'(rd_done(w8)), 32'd0);
   endtask

   initial begin
      int ra, rb, rbin;

      // Reset values, both instances.
      #1;
      chk("rst_busy4", 32'(busy4), 32'd0);
      chk("rst_done4", 32'(done4), 32'd0);
      chk("rst_diff4", 32'(diff4), 32'd0);
      chk("rst_bout4", 32'(bout4), 32'd0);
      chk("rst_diff8", 32'(diff8), 32'd0);
      chk("rst_busy8", 32'(busy8), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic operations.
      do_op(1'b0, 9, 3, 0, "op_9_3");
      do_op(1'b0, 3, 9, 0, "op_3_9");
      do_op(1'b0, 0, 0, 1, "op_0_0_bin");
      do_op(1'b0, 15, 15, 0, "op_15_15");

      // Start held high: back-to-back results every 5 cycles; a changes mid-RUN.
      a4 = 4'd8; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #1;
         chk($sformatf("b2b_done_k%0d", k), 32'(done4), 32'(k == 4 || k == 9 || k == 14));
         chk($sformatf("b2b_busy_k%0d", k), 32'(busy4),
             32'(!(k == 4 || k == 9 || k == 14)));
         if (k == 4 || k == 9 || k == 12) chk($sformatf("b2b_diff_k%0d", k), 32'(diff4), 32'd7);
         if (k == 14) chk("b2b_diff_last", 32'(diff4), 32'd1);
         if (k == 6) a4 = 4'd2;
         if (k == 14) start4 = 1'b0;
      end
      @(posedge clk); #1;
      chk("b2b_idle_busy", 32'(busy4), 32'd0);

      // Start during RUN is ignored.
      a4 = 4'd6; b4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk); #1;
      a4 = 4'd1; b4 = 4'd2; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      chk("ign_held_diff", 32'(diff4), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("ign_done", 32'(done4), 32'd1);
      chk("ign_diff", 32'(diff4), 32'd4);
      chk("ign_bout", 32'(bout4), 32'd0);
      @(posedge clk); #1;
      chk("ign_no_restart", 32'(busy4), 32'd0);

      // Asynchronous reset mid-RUN.
      a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy4), 32'd0);
      chk("arst_done", 32'(done4), 32'd0);
      chk("arst_diff", 32'(diff4), 32'd0);
      chk("arst_bout", 32'(bout4), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      do_op(1'b0, 5, 5, 0, "post_rst");

      // WIDTH=8 directed and randomized.
      do_op(1'b1, 200, 55, 1, "w8_200_55");
      for (int i = 0; i < 1000; i++) begin
         ra   = int'($urandom_range(255, 0));
         rb   = int'($urandom_range(255, 0));
         rbin = int'($urandom_range(1, 0));
         if (i < 4) begin
            rb = ra; rbin = 1;
         end
         do_op(1'b1, ra, rb, rbin, "w8_rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial ripple-borrow subtractor; computes diff = a - b - bin over WIDTH clock cycles.
- Uses a single full-subtractor cell and a registered borrow, one bit per cycle, LSB first.
- Sequential, area-minimal counterpart to the combinational ripple adder. Used where a WIDTH-bit subtract may take WIDTH cycles.
- Start/busy/done handshake. The result is held stable until the next operation completes.

Parameters:
- WIDTH, 4, operand and result width in bits (valid range 2..32).
- CW, $clog2(WIDTH+1), width of the internal bit counter. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request an operation; sampled only when busy=0.
- a  input  WIDTH  minuend; sampled at the accepting edge only.
- b  input  WIDTH  subtrahend; sampled at the accepting edge only.
- bin  input  1  borrow-in; sampled at the accepting edge only.
- diff  output  WIDTH  registered result; updates only on completion.
- bout  output  1  registered borrow-out; 1 if a < b + bin (unsigned).
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, diff=0, bout=0. Shift registers, borrow flop and counter are cleared.
- Reset mid-operation aborts the operation; diff and bout go to 0, not to a partial result.
- States are IDLE, RUN and DONE.
- IDLE: busy=0, done=0. If start=1 at an edge:
  - latch a and b into shift registers and bin into the borrow flop;
  - clear the counter;
  - go to RUN.
- RUN: busy=1. Each edge processes bit i, where x=a_sh[0], y=b_sh[0] and br=borrow flop:
  - d = x ^ y ^ br;
  - borrow_next = (~x & y) | (~(x ^ y) & br);
  - shift d into the MSB of the result shift register;
  - shift a_sh and b_sh right by one;
  - increment the counter.
- On the edge processing bit WIDTH-1:
  - copy the full result into diff and borrow_next into bout;
  - set done=1 and busy=0;
  - go to DONE.
- DONE: lasts exactly one cycle with done=1.
  - start=1 at this edge is accepted, same as in IDLE (back-to-back operation). Next state is RUN with done=0.
  - Otherwise go to IDLE with done=0.
- Latency: start accepted at edge E0 → done high in the cycle after edge E0+WIDTH. Throughput is one result per WIDTH+1 cycles when back-to-back.
- Handshake: start while busy=1 is ignored; operands are not re-sampled.
- Operands are free to change after the accepting edge.
- Arithmetic: unsigned modulo 2^WIDTH.
  - diff = (a - b - bin) mod 2^WIDTH.
  - bout = 1 iff a < b + bin.
  - bin=1 with a=b gives diff all-ones and bout=1.
- diff and bout are stable from one completion to the next, including throughout RUN of the following operation.

Test Plan:
- WIDTH=4; a=9, b=3, bin=0, start pulse → busy for 4 cycles, then done pulse for 1 cycle; diff=6, bout=0; busy=0 after.
- WIDTH=4; a=3, b=9, bin=0 → diff=10 (4'b1010), bout=1. Then a=0, b=0, bin=1 → diff=15, bout=1. Then a=15, b=15, bin=0 → diff=0, bout=0.
- WIDTH=4; start held high continuously with a=8, b=1 → results 7 each time, done pulses every 5 cycles. Change a to 2 mid-RUN → no effect until the next acceptance; the next result is 1.
- WIDTH=4; during RUN pulse start with a=1, b=2 → ignored; the current op completes with the original operands and diff holds the prior value until done.
- WIDTH=4; assert rst 2 cycles into RUN → state IDLE, busy=0, done=0, diff=0, bout=0 immediately (async). After release, a=5, b=5 → diff=0, bout=0 with normal latency.
- WIDTH=8; a=200, b=55, bin=1 → done 8 cycles after the accepting edge; diff=144, bout=0. Random 1000-op comparison against the arithmetic model.
